// File: rtl/nts_tx_arbiter.sv
// -----------------------------------------------------------------------------
// nts_tx_arbiter
//
// Round-robin arbiter that shares one TX extractor between ENGINES NTS engine
// transmit ports. One engine is granted at a time, and the grant is held for a
// whole packet, until the extractor pulses packet-read. While a grant is held,
// the granted engine's FIFO data and status reach the extractor through a
// purely combinational mux, and the extractor's read strobes go back to that
// engine only. After each grant, one RELEASE cycle gives the engine time to
// drop its packet-available level before the arbiter scans again.
//
// Ports
//   i_clk, i_reset_n             clock; synchronous active-low reset
//   i_engine_packet_available    per-engine "packet ready for TX"
//   o_engine_packet_read         per-engine packet-consumed strobe
//   i_engine_fifo_empty          per-engine TX FIFO empty
//   o_engine_fifo_rd_en          per-engine FIFO read enable
//   i_engine_fifo_rd_data        packed read data, engine k at [W*k +: W]
//   i_engine_bytes_last_word     packed, 4 bits per engine
//   o_packet_available, o_fifo_empty, o_fifo_rd_data, o_bytes_last_word
//                                extractor-facing view of the granted engine
//   i_packet_read, i_fifo_rd_en  extractor strobes, forwarded to the grant
//   o_busy                       high while a grant is held (ACTIVE)
//   o_grant_index                index of the granted / last granted engine
//   o_protocol_error             one-cycle pulse when a grant is aborted
// -----------------------------------------------------------------------------
module nts_tx_arbiter #(
    parameter int ENGINES        = 4,
    parameter int MAC_DATA_WIDTH = 64,
    localparam int GRANT_WIDTH   = (ENGINES > 1) ? $clog2(ENGINES) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,

    input  logic [ENGINES-1:0]                i_engine_packet_available,
    output logic [ENGINES-1:0]                o_engine_packet_read,
    input  logic [ENGINES-1:0]                i_engine_fifo_empty,
    output logic [ENGINES-1:0]                o_engine_fifo_rd_en,
    input  logic [MAC_DATA_WIDTH*ENGINES-1:0] i_engine_fifo_rd_data,
    input  logic [4*ENGINES-1:0]              i_engine_bytes_last_word,

    output logic                              o_packet_available,
    input  logic                              i_packet_read,
    output logic                              o_fifo_empty,
    input  logic                              i_fifo_rd_en,
    output logic [MAC_DATA_WIDTH-1:0]         o_fifo_rd_data,
    output logic [3:0]                        o_bytes_last_word,

    output logic                              o_busy,
    output logic [GRANT_WIDTH-1:0]            o_grant_index,
    output logic                              o_protocol_error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic [GRANT_WIDTH-1:0] grant_q, grant_d;
    logic [GRANT_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                   error_q, error_d;

    logic                   scan_hit;
    logic [GRANT_WIDTH-1:0] scan_idx;
    logic [GRANT_WIDTH-1:0] grant_next_ptr;
    logic                   active;

    assign active = (state_q == ST_ACTIVE);

    // Pointer value after the current grant, wrapping at ENGINES (which need
    // not be a power of two).
    assign grant_next_ptr = (grant_q == GRANT_WIDTH'(ENGINES - 1)) ? '0 : grant_q + 1'b1;

    // Round-robin scan starting at rr_ptr. Walking the offsets from highest to
    // lowest lets the lowest offset (closest to the pointer) win.
    always_comb begin
        int                     cand;
        logic [GRANT_WIDTH-1:0] cand_idx;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        scan_hit = 1'b0;
        scan_idx = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = ENGINES - 1; i >= 0; i--) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= ENGINES) begin
                cand = cand - ENGINES;
            end
            cand_idx = GRANT_WIDTH'(cand);
            if (i_engine_packet_available[cand_idx]) begin
                scan_hit = 1'b1;
                scan_idx = cand_idx;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        error_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_hit) begin
                    grant_d = scan_idx;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // A read that coincides with the engine dropping its level is a
                // normal release; only a drop without a read is an abort.
                if (i_packet_read) begin
                    state_d  = ST_RELEASE;
                    rr_ptr_d = grant_next_ptr;
                end else if (!i_engine_packet_available[grant_q]) begin
                    error_d  = 1'b1;
                    state_d  = ST_RELEASE;
                    rr_ptr_d = grant_next_ptr;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset is sampled on the clock edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            error_q  <= error_d;
        end
    end

    // Combinational forwarding: nothing passes outside ACTIVE, and the
    // extractor sees an empty FIFO with no packet pending.
    always_comb begin
        o_packet_available   = 1'b0;
        o_fifo_empty         = 1'b1;
        o_fifo_rd_data       = '0;
        o_bytes_last_word    = '0;
        o_engine_fifo_rd_en  = '0;
        o_engine_packet_read = '0;
        for (int k = 0; k < ENGINES; k++) begin
            if (active && (grant_q == GRANT_WIDTH'(k))) begin
                o_packet_available      = i_engine_packet_available[k];
                o_fifo_empty            = i_engine_fifo_empty[k];
                o_fifo_rd_data          = i_engine_fifo_rd_data[MAC_DATA_WIDTH*k +: MAC_DATA_WIDTH];
                o_bytes_last_word       = i_engine_bytes_last_word[4*k +: 4];
                o_engine_fifo_rd_en[k]  = i_fifo_rd_en;
                o_engine_packet_read[k] = i_packet_read;
            end
        end
    end

    assign o_busy           = active;
    assign o_grant_index    = grant_q;
    assign o_protocol_error = error_q;

endmodule

// File: tb/tb_nts_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nts_tx_arbiter
//
// Scoreboard bench for nts_tx_arbiter (ENGINES=4, 64-bit data). The driver
// applies one cycle of stimulus at a time and pushes the reference model's
// expected outputs for that cycle into exp_q; when the model hands out a grant
// it also pushes the engine index into grant_q. A separate monitor samples the
// DUT on the falling edge, pops exp_q every cycle and pops grant_q whenever
// o_busy rises. The reference model tracks only "which engine owns the
// extractor", a cooldown count and the next start engine.
// -----------------------------------------------------------------------------
module tb_nts_tx_arbiter;

    localparam int E = 4;
    localparam int W = 64;

    typedef struct packed {
        logic         pkt_avail;
        logic         fifo_empty;
        logic [W-1:0] data;
        logic [3:0]   blw;
        logic [E-1:0] eng_rd;
        logic [E-1:0] eng_pr;
        logic         busy;
        logic [1:0]   gidx;
        logic         err;
    } exp_t;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Stimulus variables
    logic         rst_n    = 1'b0;
    logic [E-1:0] avail    = '0;
    logic [E-1:0] empty    = '1;
    logic         rd_en    = 1'b0;
    logic         pkt_read = 1'b0;
    logic [W-1:0] eng_data [E];
    logic [3:0]   eng_blw  [E];

    logic [W*E-1:0] data_bus;
    logic [4*E-1:0] blw_bus;
    for (genvar g = 0; g < E; g++) begin : g_bus
        assign data_bus[W*g +: W] = eng_data[g];
        assign blw_bus[4*g +: 4]  = eng_blw[g];
    end

    // DUT outputs
    logic [E-1:0] o_engine_packet_read;
    logic [E-1:0] o_engine_fifo_rd_en;
    logic         o_packet_available;
    logic         o_fifo_empty;
    logic [W-1:0] o_fifo_rd_data;
    logic [3:0]   o_bytes_last_word;
    logic         o_busy;
    logic [1:0]   o_grant_index;
    logic         o_protocol_error;

    nts_tx_arbiter #(.ENGINES(E), .MAC_DATA_WIDTH(W)) dut (
        .i_clk                     (i_clk),
        .i_reset_n                 (rst_n),
        .i_engine_packet_available (avail),
        .o_engine_packet_read      (o_engine_packet_read),
        .i_engine_fifo_empty       (empty),
        .o_engine_fifo_rd_en       (o_engine_fifo_rd_en),
        .i_engine_fifo_rd_data     (data_bus),
        .i_engine_bytes_last_word  (blw_bus),
        .o_packet_available        (o_packet_available),
        .i_packet_read             (pkt_read),
        .o_fifo_empty              (o_fifo_empty),
        .i_fifo_rd_en              (rd_en),
        .o_fifo_rd_data            (o_fifo_rd_data),
        .o_bytes_last_word         (o_bytes_last_word),
        .o_busy                    (o_busy),
        .o_grant_index             (o_grant_index),
        .o_protocol_error          (o_protocol_error)
    );

    // Counters and scoreboard
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   grant_q[$];
    int   seen[$];
    int   rd2_cnt = 0;
    int   err_cnt = 0;
    bit   mon_en  = 1'b0;

    // Reference model state
    int m_owner = -1;  // engine owning the extractor, -1 when none
    int m_cool  = 0;   // cycles left before the next scan may happen
    int m_ptr   = 0;   // engine the next scan starts from
    int m_last  = 0;   // most recently granted engine
    bit m_err   = 1'b0;
    int act_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e            = '0;
        e.fifo_empty = 1'b1;
        e.gidx       = 2'(m_last);
        e.err        = m_err;
        if (m_owner >= 0) begin
            e.busy             = 1'b1;
            e.pkt_avail        = avail[m_owner];
            e.fifo_empty       = empty[m_owner];
            e.data             = eng_data[m_owner];
            e.blw              = eng_blw[m_owner];
            e.eng_rd[m_owner]  = rd_en;
            e.eng_pr[m_owner]  = pkt_read;
        end
        return e;
    endfunction

    task automatic model_edge();
        bit nerr;
        if (!rst_n) begin
            m_owner = -1;
            m_cool  = 0;
            m_ptr   = 0;
            m_last  = 0;
            m_err   = 1'b0;
            return;
        end
        nerr = 1'b0;
        if (m_owner >= 0) begin
            if (pkt_read || !avail[m_owner]) begin
                nerr    = !pkt_read;
                m_ptr   = (m_owner + 1) % E;
                m_owner = -1;
                m_cool  = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int i = 0; i < E; i++) begin
                int k;
                k = (m_ptr + i) % E;
                if (avail[k]) begin
                    m_owner = k;
                    m_last  = k;
                    grant_q.push_back(k);
                    break;
                end
            end
        end
        m_err = nerr;
    endtask

    // One clock cycle with the currently applied inputs.
    task automatic step();
        exp_q.push_back(model_out());
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic rand_bus();
        for (int k = 0; k < E; k++) begin
            eng_data[k] = {$urandom, $urandom};
            eng_blw[k]  = 4'($urandom);
        end
        empty = 4'($urandom);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        avail = '1;
        repeat (n) begin
            rand_bus();
            rd_en    = 1'($urandom);
            pkt_read = 1'($urandom);
            step();
        end
        rst_n    = 1'b1;
        avail    = '0;
        rd_en    = 1'b0;
        pkt_read = 1'b0;
        act_cnt  = 0;
    endtask

    // Extractor policy: release a grant after `hold` active cycles; optionally
    // the released engine drops its available level afterwards.
    task automatic run_policy(input int max_cycles, input int want, input int hold, input bit drop);
        for (int c = 0; c < max_cycles && seen.size() < want; c++) begin
            int owner;
            bit pr;
            rand_bus();
            owner = m_owner;
            if (owner >= 0) begin
                act_cnt++;
                rd_en    = 1'($urandom);
                pkt_read = (act_cnt >= hold);
            end else begin
                act_cnt  = 0;
                rd_en    = 1'($urandom);
                pkt_read = 1'($urandom);
            end
            pr = pkt_read;
            step();
            if (drop && pr && owner >= 0) avail[owner] = 1'b0;
        end
    endtask

    // Monitor
    initial begin
        bit prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    check("exp_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("xtr", {o_packet_available, o_fifo_empty, o_fifo_rd_data, o_bytes_last_word},
                          {e.pkt_avail, e.fifo_empty, e.data, e.blw});
                    check("eng", {o_engine_fifo_rd_en, o_engine_packet_read}, {e.eng_rd, e.eng_pr});
                    check("stat", {o_busy, o_grant_index, o_protocol_error}, {e.busy, e.gidx, e.err});
                end
                if (o_busy && !prev_busy) begin
                    seen.push_back(int'(o_grant_index));
                    if (grant_q.size() == 0) check("grant_unexpected", 1, 0);
                    else check("grant", o_grant_index, grant_q.pop_front());
                end
                if (o_engine_fifo_rd_en[2]) rd2_cnt++;
                if (o_protocol_error) err_cnt++;
                prev_busy = o_busy;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] words [3];

    initial begin
        int base;
        int fidx;
        bit released;
        for (int k = 0; k < E; k++) begin
            eng_data[k] = '0;
            eng_blw[k]  = '0;
        end
        words[0] = 64'h1111_2222_3333_4444;
        words[1] = 64'hA5A5_5A5A_DEAD_BEEF;
        words[2] = 64'h0123_4567_89AB_CDEF;

        @(posedge i_clk);
        #1;
        mon_en = 1'b1;

        // Reset: random inputs, all engines available
        do_reset(3);

        // Single requester: engine 2 with a 3-word packet
        do_reset(1);
        seen.delete();
        base     = rd2_cnt;
        fidx     = 0;
        released = 1'b0;
        empty    = '1;
        for (int k = 0; k < E; k++) eng_data[k] = {$urandom, $urandom};
        eng_blw[2] = 4'd5;
        avail[2]   = 1'b1;
        for (int c = 0; c < 14; c++) begin
            bit pr, rd;
            empty[2]    = (fidx >= 3);
            eng_data[2] = (fidx < 3) ? words[fidx] : '0;
            if (m_owner == 2 && !released) begin
                rd_en    = !empty[2];
                pkt_read = empty[2];
            end else begin
                rd_en    = 1'b0;
                pkt_read = 1'b0;
            end
            pr = pkt_read;
            rd = rd_en && !empty[2];
            step();
            if (rd) fidx++;
            if (pr) begin
                released = 1'b1;
                avail[2] = 1'b0;
            end
        end
        check("single_grants", seen.size(), 1);
        if (seen.size() > 0) check("single_idx", seen[0], 2);
        check("single_rd_words", rd2_cnt - base, 3);

        // Fairness: all engines available, release after 2 active cycles
        do_reset(1);
        seen.delete();
        avail = '1;
        run_policy(60, 6, 2, 1'b0);
        check("fair_grants", seen.size(), 6);
        if (seen.size() == 6) begin
            check("fair_order", {4'(seen[0]), 4'(seen[1]), 4'(seen[2]), 4'(seen[3]), 4'(seen[4]), 4'(seen[5])},
                  24'h012301);
        end

        // Pointer: engine 1 granted while 0 and 3 request -> 3 then 0
        do_reset(1);
        seen.delete();
        avail = 4'b0010;
        run_policy(4, 1, 100, 1'b0);
        avail = 4'b1011;
        run_policy(40, 3, 2, 1'b1);
        check("ptr_grants", seen.size(), 3);
        if (seen.size() == 3) check("ptr_order", {4'(seen[0]), 4'(seen[1]), 4'(seen[2])}, 12'h130);

        // Abort: engine 1 drops available without packet_read
        do_reset(1);
        seen.delete();
        avail = 4'b0010;
        run_policy(4, 1, 100, 1'b0);
        base  = err_cnt;
        avail = 4'b0101;
        run_policy(10, 2, 100, 1'b0);
        check("abort_err_pulses", err_cnt - base, 1);
        check("abort_grants", seen.size(), 2);
        if (seen.size() == 2) check("abort_order", {4'(seen[0]), 4'(seen[1])}, 8'h12);

        // Mid-packet reset while ACTIVE on engine 3
        do_reset(1);
        seen.delete();
        avail = 4'b1000;
        run_policy(4, 1, 100, 1'b0);
        run_policy(1, 99, 100, 1'b0);
        rst_n = 1'b0;
        avail = 4'b1001;
        step();
        rst_n = 1'b1;
        seen.delete();
        act_cnt = 0;
        run_policy(10, 1, 100, 1'b0);
        check("midrst_grants", seen.size(), 1);
        if (seen.size() > 0) check("midrst_first", seen[0], 0);

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rand_bus();
            avail    = 4'($urandom) | 4'($urandom);
            rd_en    = 1'($urandom);
            pkt_read = ($urandom_range(0, 3) == 0);
            rst_n    = ($urandom_range(0, 99) != 0);
            step();
        end

        // Drain: a grant pushed on the last edge shows up in the next cycle
        rst_n = 1'b0;
        step();
        step();
        check("exp_drain", exp_q.size(), 0);
        check("grant_drain", grant_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
